// File: rtl/usb_tx_pkg.sv
// Shared types and constants for the USB full-speed byte-level transmit sequencer.
package usb_tx_pkg;

    localparam int unsigned MAX_PKT_DEF = 64;
    localparam int unsigned OCC_W_DEF   = 7;
    localparam int unsigned BYTE_W      = 8;
    localparam int unsigned CRC_W       = 16;

    typedef enum logic [2:0] {
        CMD_NONE  = 3'd0,
        CMD_DATA0 = 3'd1,
        CMD_ACK   = 3'd2,
        CMD_NAK   = 3'd3,
        CMD_STALL = 3'd4
    } tx_cmd_e;

    localparam logic [BYTE_W-1:0] PID_DATA0 = 8'hC3;
    localparam logic [BYTE_W-1:0] PID_ACK   = 8'hD2;
    localparam logic [BYTE_W-1:0] PID_NAK   = 8'h5A;
    localparam logic [BYTE_W-1:0] PID_STALL = 8'h1E;
    localparam logic [BYTE_W-1:0] SYNC_BYTE = 8'h80;

    localparam logic [CRC_W-1:0] CRC16_POLY_R = 16'hA001;
    localparam logic [CRC_W-1:0] CRC16_INIT   = 16'hFFFF;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_SYNC   = 4'd1,
        ST_PID    = 4'd2,
        ST_FETCH  = 4'd3,
        ST_WAITRD = 4'd4,
        ST_DATA   = 4'd5,
        ST_CRC_LO = 4'd6,
        ST_CRC_HI = 4'd7,
        ST_EOP    = 4'd8
    } tx_state_e;

    // Reflected CRC16 over one byte, LSB first.
    function automatic logic [CRC_W-1:0] crc16_byte(input logic [CRC_W-1:0] crc,
                                                    input logic [BYTE_W-1:0] data);
        logic [CRC_W-1:0] c;
        c = crc;
        for (int i = 0; i < 8; i++) begin
            c = (c[0] ^ data[i]) ? ((c >> 1) ^ CRC16_POLY_R) : (c >> 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/usb_crc16.sv
// Byte-wide USB CRC16 register; crc_next_c exposes the value loaded on the next edge.
module usb_crc16
    import usb_tx_pkg::*;
(
    input  logic              clk,
    input  logic              clear,
    input  logic              enable,
    input  logic [BYTE_W-1:0] data,
    output logic [CRC_W-1:0]  crc,
    output logic [CRC_W-1:0]  crc_next_c
);

    always_comb begin
        crc_next_c = crc;
        if (clear) begin
            crc_next_c = CRC16_INIT;
        end else if (enable) begin
            crc_next_c = crc16_byte(crc, data);
        end
    end

    always_ff @(posedge clk) begin
        crc <= crc_next_c;
    end

endmodule

// File: rtl/usb_tx_ctrl.sv
// USB full-speed TX byte sequencer: SYNC, PID, payload and CRC16 bytes to the serializer, then EOP.
module usb_tx_ctrl
    import usb_tx_pkg::*;
#(
    parameter int unsigned MAX_PKT = MAX_PKT_DEF,
    parameter int unsigned OCC_W   = OCC_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [2:0]        tx_packet,
    input  logic [OCC_W-1:0]  buffer_occupancy,
    input  logic [BYTE_W-1:0] tx_packet_data,
    input  logic              byte_ready,
    input  logic              eop_ack,
    output logic              get_tx_packet_data,
    output logic [BYTE_W-1:0] tx_byte,
    output logic              byte_valid,
    output logic              eop_req,
    output logic              tx_transfer_active,
    output logic              tx_error
);

    tx_state_e         state, state_next;
    logic [BYTE_W-1:0] pid_q, pid_c;
    logic              is_data_q;
    logic [OCC_W-1:0]  len_q, cnt_q;
    logic              xfer_c, cmd_ok_c, cmd_bad_c, accept_c;
    logic [CRC_W-1:0]  crc, crc_next_c;
    logic              crc_clear_c, crc_en_c;

    logic              get_d, valid_d, eop_d, active_d, error_d;
    logic [BYTE_W-1:0] byte_d;

    assign xfer_c      = byte_valid & byte_ready;
    assign accept_c    = (state == ST_IDLE) && cmd_ok_c;
    assign crc_clear_c = rst | ((state == ST_EOP) && eop_ack);
    assign crc_en_c    = (state == ST_DATA) && xfer_c;

    usb_crc16 u_crc (
        .clk        (clk),
        .clear      (crc_clear_c),
        .enable     (crc_en_c),
        .data       (tx_byte),
        .crc        (crc),
        .crc_next_c (crc_next_c)
    );

    // Command decode: PID selection and rejection of illegal / oversize requests.
    always_comb begin
        cmd_ok_c  = 1'b0;
        cmd_bad_c = 1'b0;
        pid_c     = PID_ACK;
        case (tx_packet)
            CMD_NONE: ;
            CMD_DATA0: begin
                if (buffer_occupancy > OCC_W'(MAX_PKT)) begin
                    cmd_bad_c = 1'b1;
                end else begin
                    cmd_ok_c = 1'b1;
                    pid_c    = PID_DATA0;
                end
            end
            CMD_ACK:   begin cmd_ok_c = 1'b1; pid_c = PID_ACK;   end
            CMD_NAK:   begin cmd_ok_c = 1'b1; pid_c = PID_NAK;   end
            CMD_STALL: begin cmd_ok_c = 1'b1; pid_c = PID_STALL; end
            default:   cmd_bad_c = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:   if (cmd_ok_c) state_next = ST_SYNC;
            ST_SYNC:   if (xfer_c) state_next = ST_PID;
            ST_PID: begin
                if (xfer_c) begin
                    if (!is_data_q)          state_next = ST_EOP;
                    else if (len_q == '0)    state_next = ST_CRC_LO;
                    else                     state_next = ST_FETCH;
                end
            end
            ST_FETCH:  state_next = ST_WAITRD;
            ST_WAITRD: state_next = ST_DATA;
            ST_DATA: begin
                if (xfer_c) begin
                    state_next = (cnt_q + OCC_W'(1) == len_q) ? ST_CRC_LO : ST_FETCH;
                end
            end
            ST_CRC_LO: if (xfer_c) state_next = ST_CRC_HI;
            ST_CRC_HI: if (xfer_c) state_next = ST_EOP;
            ST_EOP:    if (eop_ack) state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    // Output values for the next cycle; tx_byte is loaded only on state entry so it holds while waiting.
    always_comb begin
        get_d    = 1'b0;
        valid_d  = 1'b0;
        eop_d    = 1'b0;
        byte_d   = tx_byte;
        active_d = (state_next != ST_IDLE);
        error_d  = (state == ST_IDLE) && cmd_bad_c;
        case (state_next)
            ST_SYNC: begin
                valid_d = 1'b1;
                byte_d  = SYNC_BYTE;
            end
            ST_PID: begin
                valid_d = 1'b1;
                byte_d  = pid_q;
            end
            ST_FETCH: get_d = 1'b1;
            ST_DATA: begin
                valid_d = 1'b1;
                if (state == ST_WAITRD) byte_d = tx_packet_data;
            end
            ST_CRC_LO: begin
                valid_d = 1'b1;
                if (state != ST_CRC_LO) byte_d = ~crc_next_c[7:0];
            end
            ST_CRC_HI: begin
                valid_d = 1'b1;
                if (state != ST_CRC_HI) byte_d = ~crc[15:8];
            end
            ST_EOP: eop_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            get_tx_packet_data <= 1'b0;
            tx_byte            <= '0;
            byte_valid         <= 1'b0;
            eop_req            <= 1'b0;
            tx_transfer_active <= 1'b0;
            tx_error           <= 1'b0;
        end else begin
            get_tx_packet_data <= get_d;
            tx_byte            <= byte_d;
            byte_valid         <= valid_d;
            eop_req            <= eop_d;
            tx_transfer_active <= active_d;
            tx_error           <= error_d;
        end
    end

    // Packet context latched at command acceptance; payload counter advances per sent data byte.
    always_ff @(posedge clk) begin
        if (rst) begin
            pid_q     <= '0;
            is_data_q <= 1'b0;
            len_q     <= '0;
            cnt_q     <= '0;
        end else if (accept_c) begin
            pid_q     <= pid_c;
            is_data_q <= (tx_packet == CMD_DATA0);
            len_q     <= (tx_packet == CMD_DATA0) ? buffer_occupancy : '0;
            cnt_q     <= '0;
        end else if (crc_en_c) begin
            cnt_q     <= cnt_q + OCC_W'(1);
        end
    end

endmodule

// File: tb/tb_usb_tx_ctrl.sv
// Directed bench for usb_tx_ctrl: handshake packets, DATA0 with CRC16, stalls, rejects and mid-packet reset.
module tb_usb_tx_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] tx_packet = 3'd0;
    logic [6:0] buffer_occupancy = 7'd0;
    logic [7:0] tx_packet_data = 8'h00;
    logic       byte_ready = 1'b0;
    logic       eop_ack = 1'b0;
    logic       get_tx_packet_data;
    logic [7:0] tx_byte;
    logic       byte_valid;
    logic       eop_req;
    logic       tx_transfer_active;
    logic       tx_error;

    int checks = 0;
    int errors = 0;
    int xfers  = 0;
    int pops   = 0;
    int base_x = 0;
    int base_p = 0;
    bit stall_mode = 1'b0;
    logic [7:0] mem [16];

    always #5 clk = ~clk;

    usb_tx_ctrl dut (
        .clk                (clk),
        .rst                (rst),
        .tx_packet          (tx_packet),
        .buffer_occupancy   (buffer_occupancy),
        .tx_packet_data     (tx_packet_data),
        .byte_ready         (byte_ready),
        .eop_ack            (eop_ack),
        .get_tx_packet_data (get_tx_packet_data),
        .tx_byte            (tx_byte),
        .byte_valid         (byte_valid),
        .eop_req            (eop_req),
        .tx_transfer_active (tx_transfer_active),
        .tx_error           (tx_error)
    );

    // TX buffer model: data appears the cycle after a pop.
    always @(posedge clk) begin
        if (!rst && byte_valid && byte_ready) xfers <= xfers + 1;
        if (get_tx_packet_data) begin
            tx_packet_data <= mem[4'(pops - base_p)];
            pops <= pops + 1;
        end
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_byte(input string tag, input logic [7:0] exp);
        int stall;
        int dx;
        bit seen;
        bit got;
        logic [7:0] held;
        stall = stall_mode ? int'($urandom_range(0, 20)) : 0;
        seen = 1'b0;
        got  = 1'b0;
        held = 8'h00;
        for (int n = 0; n < 400 && !got; n++) begin
            @(negedge clk);
            if (seen) check({tag, " stable"}, {7'd0, byte_valid, tx_byte}, {8'h01, held});
            dx = xfers - base_x;
            dx = (dx > 2) ? dx - 2 : 0;
            check({tag, " pop bound"}, 16'(((pops - base_p) <= dx + 1) ? 1 : 0), 16'd1);
            if (byte_valid && !seen) begin
                seen = 1'b1;
                held = tx_byte;
            end
            byte_ready = (stall == 0);
            if (seen && stall > 0) stall--;
            if (byte_valid && byte_ready) begin
                got = 1'b1;
                check(tag, 16'(tx_byte), 16'(exp));
            end
        end
        check({tag, " handshake"}, 16'(got), 16'd1);
        @(posedge clk);
        #1 byte_ready = 1'b0;
    endtask

    task automatic start_cmd(input logic [2:0] cmd, input logic [6:0] occ);
        @(negedge clk);
        tx_packet        = cmd;
        buffer_occupancy = occ;
        base_x           = xfers;
        base_p           = pops;
        @(negedge clk);
        tx_packet = 3'd0;
        check("active after accept", 16'(tx_transfer_active), 16'd1);
        check("no error on accept", 16'(tx_error), 16'd0);
    endtask

    task automatic finish_eop(input string tag, input int exp_x, input int exp_p);
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < 50 && !seen; n++) begin
            @(negedge clk);
            seen = eop_req;
        end
        check({tag, " eop_req"}, 16'(seen), 16'd1);
        check({tag, " valid low in eop"}, 16'(byte_valid), 16'd0);
        check({tag, " active in eop"}, 16'(tx_transfer_active), 16'd1);
        eop_ack = 1'b1;
        @(negedge clk);
        eop_ack = 1'b0;
        check({tag, " active drop"}, 16'(tx_transfer_active), 16'd0);
        check({tag, " eop_req drop"}, 16'(eop_req), 16'd0);
        check({tag, " byte count"}, 16'(xfers - base_x), 16'(exp_x));
        check({tag, " pop count"}, 16'(pops - base_p), 16'(exp_p));
    endtask

    task automatic reject(input string tag, input logic [2:0] cmd, input logic [6:0] occ);
        @(negedge clk);
        tx_packet        = cmd;
        buffer_occupancy = occ;
        @(negedge clk);
        tx_packet = 3'd0;
        check({tag, " error pulse"}, 16'(tx_error), 16'd1);
        check({tag, " not active"}, 16'(tx_transfer_active), 16'd0);
        @(negedge clk);
        check({tag, " error ends"}, 16'(tx_error), 16'd0);
        check({tag, " still idle"}, 16'(tx_transfer_active | byte_valid), 16'd0);
    endtask

    task automatic data0_9(input string tag);
        start_cmd(3'd1, 7'd9);
        expect_byte({tag, " sync"}, 8'h80);
        expect_byte({tag, " pid"}, 8'hC3);
        for (int i = 0; i < 9; i++) expect_byte({tag, " payload"}, 8'h31 + 8'(i));
        expect_byte({tag, " crc lo"}, 8'hC8);
        expect_byte({tag, " crc hi"}, 8'hB4);
        finish_eop(tag, 13, 9);
    endtask

    initial begin
        bit found;
        for (int i = 0; i < 16; i++) mem[i] = (i < 9) ? 8'h31 + 8'(i) : 8'hEE;

        repeat (3) @(negedge clk);
        check("reset valid", 16'(byte_valid), 16'd0);
        check("reset byte", 16'(tx_byte), 16'd0);
        check("reset pop", 16'(get_tx_packet_data), 16'd0);
        check("reset misc", {13'd0, eop_req, tx_transfer_active, tx_error}, 16'd0);
        rst = 1'b0;

        // ACK handshake packet
        start_cmd(3'd2, 7'd0);
        expect_byte("ack sync", 8'h80);
        expect_byte("ack pid", 8'hD2);
        finish_eop("ack", 2, 0);

        // DATA0 with empty payload
        start_cmd(3'd1, 7'd0);
        expect_byte("empty sync", 8'h80);
        expect_byte("empty pid", 8'hC3);
        expect_byte("empty crc lo", 8'h00);
        expect_byte("empty crc hi", 8'h00);
        finish_eop("empty", 4, 0);

        data0_9("d9");
        stall_mode = 1'b1;
        data0_9("d9 stall");
        stall_mode = 1'b0;

        reject("cmd6", 3'd6, 7'd0);
        reject("occ65", 3'd1, 7'd65);

        // Command during a packet is ignored
        start_cmd(3'd3, 7'd0);
        expect_byte("busy sync", 8'h80);
        tx_packet = 3'd4;
        @(negedge clk);
        @(negedge clk);
        tx_packet = 3'd0;
        check("busy no error", 16'(tx_error), 16'd0);
        expect_byte("busy pid", 8'h5A);
        finish_eop("busy", 2, 0);
        repeat (3) @(negedge clk);
        check("busy no requeue", 16'(tx_transfer_active | byte_valid), 16'd0);

        // Reset while a payload byte is offered
        start_cmd(3'd1, 7'd9);
        expect_byte("rst sync", 8'h80);
        expect_byte("rst pid", 8'hC3);
        expect_byte("rst b0", 8'h31);
        found = 1'b0;
        for (int n = 0; n < 20 && !found; n++) begin
            @(negedge clk);
            found = byte_valid;
        end
        check("rst reached data", 16'(found), 16'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid rst valid", 16'(byte_valid), 16'd0);
        check("mid rst byte", 16'(tx_byte), 16'd0);
        check("mid rst pop", 16'(get_tx_packet_data), 16'd0);
        check("mid rst misc", {13'd0, eop_req, tx_transfer_active, tx_error}, 16'd0);
        start_cmd(3'd2, 7'd0);
        expect_byte("post rst sync", 8'h80);
        expect_byte("post rst pid", 8'hD2);
        finish_eop("post rst", 2, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/usb_tx_ctrl.md
Name: usb_tx_ctrl

Overview:
Byte-level sequencer for the USB full-speed transmitter. It accepts a packet command from the protocol controller and pulls payload bytes from the TX data buffer. It hands SYNC, PID, payload and CRC16 bytes, in order, to the bit-level serializer (NRZI, bit-stuff and bit timing). It then requests EOP and reports transfer-active and error status.

Parameters:
MAX_PKT, 64, maximum payload bytes in a DATA0 packet.
OCC_W, 7, width of buffer_occupancy and of the internal byte counter.

Ports:
clk  in  1  system clock.
rst  in  1  synchronous, active-high reset.
tx_packet  in  3  command: 0 none, 1 DATA0, 2 ACK, 3 NAK, 4 STALL, 5-7 illegal.
buffer_occupancy  in  OCC_W  bytes currently held in the TX buffer.
tx_packet_data  in  8  buffer read data, valid the cycle after get_tx_packet_data.
byte_ready  in  1  serializer can take a byte.
eop_ack  in  1  serializer has finished driving EOP (one-cycle pulse).
get_tx_packet_data  out  1  one-cycle buffer pop strobe.
tx_byte  out  8  byte to the serializer, sent LSB first.
byte_valid  out  1  tx_byte is valid.
eop_req  out  1  request EOP from the serializer.
tx_transfer_active  out  1  packet in progress.
tx_error  out  1  one-cycle pulse on a rejected command.

Behaviour:
- Reset: synchronous, active-high, overrides everything, including mid-packet. On reset the FSM goes to IDLE and all outputs are 0, tx_byte included. The CRC register is set to 0xFFFF and the byte counter to 0. No partial byte or EOP is guaranteed after a mid-packet reset.
- Byte handshake: a byte transfers on a cycle where byte_valid and byte_ready are both high. Once byte_valid is asserted, tx_byte and byte_valid stay stable until the transfer cycle. byte_valid never depends combinationally on byte_ready.
- States: IDLE, SYNC, PID, FETCH, WAITRD, DATA, CRC_LO, CRC_HI, EOP.
- IDLE, command 1-4 accepted:
  - Latch the PID: DATA0 0xC3, ACK 0xD2, NAK 0x5A, STALL 0x1E.
  - For DATA0, latch len = buffer_occupancy.
  - Go to SYNC.
  - tx_transfer_active goes high the next cycle and stays high until the cycle after eop_ack.
- IDLE, rejected commands: the FSM stays in IDLE and tx_error pulses for 1 cycle (next cycle) when:
  - the command is 5-7, or
  - the command is DATA0 with buffer_occupancy > MAX_PKT.
- Busy: tx_packet is ignored while not in IDLE (no queueing). A command still held on return to IDLE starts a new packet.
- SYNC: drives 0x80; after transfer goes to PID.
- PID: drives the latched PID; after transfer goes to:
  - EOP for handshake packets (ACK/NAK/STALL);
  - CRC_LO for DATA0 with len = 0;
  - FETCH otherwise.
- FETCH: get_tx_packet_data = 1 for exactly one cycle, then WAITRD.
- WAITRD: captures tx_packet_data into tx_byte, then DATA.
- DATA:
  - On transfer: update the CRC with the byte and increment the counter.
  - If counter+1 == len, go to CRC_LO; else go to FETCH.
  - Minimum spacing between pops is 3 cycles. There is at most one pop per payload byte and exactly len pops per packet.
- CRC16 (USB):
  - Reflected polynomial 0xA001, init 0xFFFF, processed LSB first.
  - Transmitted value is ~crc.
  - CRC_LO drives the low byte and CRC_HI the high byte; after transfer CRC_HI goes to EOP.
- EOP:
  - eop_req is high, byte_valid low.
  - On eop_ack: eop_req drops, the CRC is re-initialised and the FSM goes to IDLE.
  - tx_transfer_active drops in the same cycle the FSM reaches IDLE.
- An eop_ack or byte_ready seen outside its waiting state is ignored.
- Counter width is OCC_W; len ≤ 64, so there is no wrap.

Decomposition:
- Package usb_tx_pkg:
  - tx_packet command enum;
  - PID constants;
  - SYNC_BYTE = 0x80;
  - CRC16_POLY_R = 16'hA001, CRC16_INIT = 16'hFFFF;
  - FSM state enum.
- Sub-module usb_crc16: byte-wide CRC16 register. Inputs: clear, enable, data[7:0]. Output: crc[15:0]. Eight unrolled LSB-first iterations, combinational next-state.

Test Plan:
- ACK with byte_ready tied 1 → byte stream 0x80, 0xD2, then eop_req. No get_tx_packet_data pulses. On eop_ack, tx_transfer_active falls. tx_error stays 0.
- DATA0 with occupancy 0 → stream 0x80, 0xC3, 0x00, 0x00, then EOP. Zero pops.
- DATA0 with ASCII "123456789" (9 bytes) → exactly 9 pops. Stream 0x80, 0xC3, 0x31…0x39, then 0xC8, 0xB4 (CRC 0xB4C8), then EOP.
- Random byte_ready stalls of 0-20 cycles during the previous case:
  - tx_byte is stable while byte_valid is high;
  - the byte sequence is identical;
  - buffer pops never exceed transferred bytes + 1.
- Rejected commands:
  - command 6 → one tx_error pulse, tx_transfer_active stays 0;
  - DATA0 with occupancy 65 → same;
  - a second command during a packet is ignored.
- rst asserted mid-DATA → the next cycle all outputs are 0 and the FSM is in IDLE. A following ACK command produces a correct 0x80, 0xD2 sequence.
